// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin hand-off from the acceptor to the vending machine.
// Latency: none; a plain bundle of wires.
// Backpressure: coin_ready from the slave holds xin/coin_valid in place until a pop.
// Build option COIN_REJECT_CNT_EN adds the reject_cnt member.
interface coin_acceptor_if;
   logic [3:0] xin;
   logic       coin_valid;
   logic       coin_ready;
   logic       fifo_full;
   logic       reject_pulse;
`ifdef COIN_REJECT_CNT_EN
   logic [7:0] reject_cnt;

   modport master (output xin, output coin_valid, output fifo_full,
                   output reject_pulse, output reject_cnt, input coin_ready);
   modport slave  (input xin, input coin_valid, input fifo_full,
                   input reject_pulse, input reject_cnt, output coin_ready);
`else
   modport master (output xin, output coin_valid, output fifo_full,
                   output reject_pulse, input coin_ready);
   modport slave  (input xin, input coin_valid, input fifo_full,
                   input reject_pulse, output coin_ready);
`endif
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes/debounces nickel and dime sensors, queues accepted coins, flags rejects.
// Latency: coin_valid rises DEB_CYCLES+3 clocks after a clean sensor rise is first sampled (empty queue).
// Backpressure: head coin held on xin until coin_ready; a coin meeting a full queue with no pop is rejected.
// Build option COIN_REJECT_CNT_EN adds the saturating reject_cnt output.
module coin_acceptor #(
   parameter int DEB_CYCLES = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            nickel_in,
   input  logic            dime_in,
   coin_acceptor_if.master coin
);
   localparam int             PW          = $clog2(FIFO_DEPTH);
   localparam logic [3:0]     DEB_C       = DEB_CYCLES[3:0];
   localparam logic [3:0]     DEB_M1_C    = DEB_C - 4'd1;
   localparam logic [PW:0]    DEPTH_C     = FIFO_DEPTH[PW:0];
   localparam logic [PW:0]    CNT_ONE     = (PW+1)'(1);
   localparam logic [PW-1:0]  PTR_ONE     = PW'(1);
   localparam logic [3:0]     CODE_NICKEL = 4'b0101;
   localparam logic [3:0]     CODE_DIME   = 4'b1010;

   typedef enum logic [2:0] {IDLE, QUAL, PUSH, REJECT, WAIT_LOW} state_t;

   // two-stage synchronizers
   logic nick_s1_q, nick_s1_d, nick_s2_q, nick_s2_d;
   logic dime_s1_q, dime_s1_d, dime_s2_q, dime_s2_d;

   // qualify FSM
   state_t     state_q, state_d;
   logic [3:0] qcnt_q, qcnt_d;
   logic       is_dime_q, is_dime_d;

   // coin queue
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [3:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   // registered outputs
   logic [3:0] xin_q, xin_d;
   logic       valid_q, valid_d;
   logic       full_q, full_d;
   logic       rej_pulse_q, rej_pulse_d;

   // combinational helpers
   logic latched_hi, push, fsm_rej, pop, full, do_push, push_rej;

   // Next state for synchronizers, qualify FSM, queue and the registered outputs.
   always_comb begin
      nick_s1_d  = nickel_in;
      nick_s2_d  = nick_s1_q;
      dime_s1_d  = dime_in;
      dime_s2_d  = dime_s1_q;
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      is_dime_d  = is_dime_q;
      push       = 1'b0;
      fsm_rej    = 1'b0;
      latched_hi = is_dime_q ? dime_s2_q : nick_s2_q;

      case (state_q)
         IDLE: begin
            if (nick_s2_q && dime_s2_q) begin
               state_d = REJECT;
               fsm_rej = 1'b1;
            end else if (nick_s2_q ^ dime_s2_q) begin
               state_d   = QUAL;
               qcnt_d    = 4'd1;
               is_dime_d = dime_s2_q;
            end
         end
         QUAL: begin
            // Both sensors high is a jam or a fraud attempt, never a coin.
            if (nick_s2_q && dime_s2_q) begin
               state_d = REJECT;
               fsm_rej = 1'b1;
            end else if (qcnt_q == DEB_C) begin
               state_d = PUSH;
            end else if (!latched_hi) begin
               state_d = IDLE;
               qcnt_d  = 4'd0;
            end else begin
               qcnt_d = qcnt_q + 4'd1;
            end
         end
         PUSH: begin
            push    = 1'b1;
            state_d = WAIT_LOW;
            qcnt_d  = 4'd0;
         end
         REJECT: begin
            state_d = WAIT_LOW;
            qcnt_d  = 4'd0;
         end
         WAIT_LOW: begin
            // The coin must clear both sensors before the next one is considered.
            if (nick_s2_q || dime_s2_q) begin
               qcnt_d = 4'd0;
            end else if (qcnt_q == DEB_M1_C) begin
               state_d = IDLE;
               qcnt_d  = 4'd0;
            end else begin
               qcnt_d = qcnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            qcnt_d  = 4'd0;
         end
      endcase

      pop      = (count_q != '0) && coin.coin_ready;
      full     = (count_q == DEPTH_C);
      do_push  = push && (!full || pop);
      push_rej = push && full && !pop;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = is_dime_q ? CODE_DIME : CODE_NICKEL;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !do_push) begin
         count_d = count_q - CNT_ONE;
      end

      // Outputs reflect the queue after this edge; a push into an empty queue shows up next cycle.
      valid_d     = (count_d != '0);
      full_d      = (count_d == DEPTH_C);
      xin_d       = valid_d ? mem_d[rd_ptr_d] : 4'b0000;
      rej_pulse_d = fsm_rej | push_rej;
   end

   // All state and outputs register here; reset drops any coin in flight or queued.
   always_ff @(posedge clk) begin
      if (reset) begin
         nick_s1_q   <= 1'b0;
         nick_s2_q   <= 1'b0;
         dime_s1_q   <= 1'b0;
         dime_s2_q   <= 1'b0;
         state_q     <= IDLE;
         qcnt_q      <= 4'd0;
         is_dime_q   <= 1'b0;
         mem_q       <= '{default: 4'b0000};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         xin_q       <= 4'b0000;
         valid_q     <= 1'b0;
         full_q      <= 1'b0;
         rej_pulse_q <= 1'b0;
      end else begin
         nick_s1_q   <= nick_s1_d;
         nick_s2_q   <= nick_s2_d;
         dime_s1_q   <= dime_s1_d;
         dime_s2_q   <= dime_s2_d;
         state_q     <= state_d;
         qcnt_q      <= qcnt_d;
         is_dime_q   <= is_dime_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         xin_q       <= xin_d;
         valid_q     <= valid_d;
         full_q      <= full_d;
         rej_pulse_q <= rej_pulse_d;
      end
   end

   assign coin.xin          = xin_q;
   assign coin.coin_valid   = valid_q;
   assign coin.fifo_full    = full_q;
   assign coin.reject_pulse = rej_pulse_q;

`ifdef COIN_REJECT_CNT_EN
   logic [7:0] rej_cnt_q, rej_cnt_d;

   // Saturating reject count, stepping on the same edge the pulse appears.
   always_comb begin
      rej_cnt_d = rej_cnt_q;
      if (rej_pulse_d && (rej_cnt_q != 8'hFF)) begin
         rej_cnt_d = rej_cnt_q + 8'd1;
      end
   end

   // Reject counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         rej_cnt_q <= 8'd0;
      end else begin
         rej_cnt_q <= rej_cnt_d;
      end
   end

   assign coin.reject_cnt = rej_cnt_q;
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized and directed sensor episodes against an event-level model.
// Latency: model places each accepted coin DEB+3 edges after its first sampled rise.
// Backpressure: coin_ready is driven directly or randomized per cycle.
module tb_coin_acceptor;
   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   logic nickel_in;
   logic dime_in;

   coin_acceptor_if cif ();

   coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .nickel_in (nickel_in),
      .dime_in   (dime_in),
      .coin      (cif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // model state: queue contents and per-edge scheduled events
   logic [3:0] mq [$];
   logic [3:0] push_sched [int];
   bit         rej_sched [int];
   bit         exp_rej = 1'b0;
   int         exp_cnt = 0;

   // observation counters for directed checks
   int         valid_hi  = 0;
   int         rej_seen  = 0;
   int         last_rise = -1;
   logic [3:0] rise_xin  = 4'b0000;
   bit         prev_valid = 1'b0;
   bit         rnd_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model step at each edge, then compare the DUT 1 time unit later.
   initial begin
      bit pop;
      bit full;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            mq.delete();
            push_sched.delete();
            rej_sched.delete();
            exp_rej = 1'b0;
            exp_cnt = 0;
         end else begin
            pop     = (mq.size() != 0) && (cif.coin_ready === 1'b1);
            full    = (mq.size() == DEPTH);
            exp_rej = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push_sched.exists(cyc)) begin
               if (full && !pop) exp_rej = 1'b1;
               else mq.push_back(push_sched[cyc]);
            end
            if (rej_sched.exists(cyc)) exp_rej = 1'b1;
            if (exp_rej && exp_cnt < 255) exp_cnt++;
         end
         #1;
         chk("coin_valid", 32'(cif.coin_valid), 32'(mq.size() != 0));
         chk("xin", 32'(cif.xin), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
         chk("fifo_full", 32'(cif.fifo_full), 32'(mq.size() == DEPTH));
         chk("reject_pulse", 32'(cif.reject_pulse), 32'(exp_rej));
`ifdef COIN_REJECT_CNT_EN
         chk("reject_cnt", 32'(cif.reject_cnt), 32'(exp_cnt));
`endif
         if (cif.coin_valid === 1'b1) valid_hi++;
         if ((cif.coin_valid === 1'b1) && !prev_valid) begin
            last_rise = cyc;
            rise_xin  = cif.xin;
         end
         prev_valid = (cif.coin_valid === 1'b1);
         if (cif.reject_pulse === 1'b1) rej_seen++;
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rnd_ready) cif.coin_ready = 1'($urandom_range(0, 1));
   endtask

   // One sensor episode: n/d held high for len cycles, then a quiet gap.
   task automatic coin_event(input bit n, input bit d, input int len, input int gap);
      int e0;
      e0 = cyc + 1;
      if (n && d) rej_sched[e0 + 2] = 1'b1;
      else if ((n || d) && len >= DEB) push_sched[e0 + DEB + 3] = n ? 4'b0101 : 4'b1010;
      nickel_in = n;
      dime_in   = d;
      repeat (len) tick();
      nickel_in = 1'b0;
      dime_in   = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int e0, v0, r0;
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0000};
      nickel_in      = 1'b0;
      dime_in        = 1'b0;
      reset          = 1'b1;
      cif.coin_ready = 1'b0;
      repeat (3) tick();
      chk("reset_valid", 32'(cif.coin_valid), 32'd0);
      chk("reset_xin", 32'(cif.xin), 32'd0);
      chk("reset_full", 32'(cif.fifo_full), 32'd0);
      chk("reset_reject", 32'(cif.reject_pulse), 32'd0);
      reset = 1'b0;
      tick();

      // clean nickel with ready high
      cif.coin_ready = 1'b1;
      v0 = valid_hi;
      e0 = cyc + 1;
      coin_event(1'b1, 1'b0, 10, 8);
      chk("nickel_latency", 32'(last_rise - e0), 32'd7);
      chk("nickel_valid_cycles", 32'(valid_hi - v0), 32'd1);
      chk("nickel_code", 32'(rise_xin), 32'h5);

      // dime glitch filtered, then a clean dime
      v0 = valid_hi;
      r0 = rej_seen;
      coin_event(1'b0, 1'b1, 2, 8);
      chk("glitch_no_coin", 32'(valid_hi - v0), 32'd0);
      chk("glitch_no_reject", 32'(rej_seen - r0), 32'd0);
      coin_event(1'b0, 1'b1, 6, 8);
      chk("dime_valid_cycles", 32'(valid_hi - v0), 32'd1);
      chk("dime_code", 32'(rise_xin), 32'hA);

      // both sensors together
      v0 = valid_hi;
      r0 = rej_seen;
      coin_event(1'b1, 1'b1, 3, 8);
      chk("both_reject", 32'(rej_seen - r0), 32'd1);
      chk("both_no_coin", 32'(valid_hi - v0), 32'd0);
`ifdef COIN_REJECT_CNT_EN
      chk("both_reject_cnt", 32'(cif.reject_cnt), 32'd1);
`endif

      // fill the queue with ready low, fifth coin rejected, then drain in order
      cif.coin_ready = 1'b0;
      coin_event(1'b1, 1'b0, 6, 8);
      coin_event(1'b0, 1'b1, 6, 8);
      coin_event(1'b1, 1'b0, 6, 8);
      coin_event(1'b0, 1'b1, 6, 8);
      chk("full_after_four", 32'(cif.fifo_full), 32'd1);
      r0 = rej_seen;
      coin_event(1'b1, 1'b0, 6, 8);
      chk("fifth_rejected", 32'(rej_seen - r0), 32'd1);
      chk("still_full", 32'(cif.fifo_full), 32'd1);
      cif.coin_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_xin", 32'(cif.xin), 32'(exp_seq[i]));
         tick();
      end

      // two queued coins wiped by a one-cycle reset
      cif.coin_ready = 1'b0;
      coin_event(1'b1, 1'b0, 6, 8);
      coin_event(1'b0, 1'b1, 6, 8);
      chk("two_queued_valid", 32'(cif.coin_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("post_reset_valid", 32'(cif.coin_valid), 32'd0);
         chk("post_reset_xin", 32'(cif.xin), 32'd0);
`ifdef COIN_REJECT_CNT_EN
         chk("post_reset_cnt", 32'(cif.reject_cnt), 32'd0);
`endif
         tick();
      end

      // reset in the middle of qualifying a nickel
      cif.coin_ready = 1'b1;
      v0 = valid_hi;
      nickel_in = 1'b1;
      repeat (4) tick();
      reset     = 1'b1;
      nickel_in = 1'b0;
      tick();
      reset = 1'b0;
      repeat (15) tick();
      chk("midqual_reset_no_coin", 32'(valid_hi - v0), 32'd0);

      // randomized episodes with random backpressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         case (kind)
            0, 1:    coin_event(1'b1, 1'b0, int'($urandom_range(1, 8)), int'($urandom_range(8, 12)));
            2, 3:    coin_event(1'b0, 1'b1, int'($urandom_range(1, 8)), int'($urandom_range(8, 12)));
            default: coin_event(1'b1, 1'b1, int'($urandom_range(1, 8)), int'($urandom_range(8, 12)));
         endcase
      end
      rnd_ready      = 1'b0;
      cif.coin_ready = 1'b1;
      repeat (20) tick();
      chk("drained_empty", 32'(cif.coin_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
